alu_mc: RTL and testbench

//  Parametrised multi-cycle ALU for the next CPU generation, with valid/ready handshakes on input and output.

---
 rtl/alu_mc_pkg.sv | 34 +++
 rtl/alu_mc_iter.sv | 103 ++++++++++
 rtl/alu_mc.sv | 142 ++++++++++++++
 tb/tb_alu_mc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: op codes, FSM state encoding and op classification for alu_mc.
// Optional divider controlled by macro ALU_MC_DIV_EN.
package alu_mc_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OR   = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_DIVU = 4'b1011;
    localparam logic [3:0] ALU_REMU = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ops routed to the iterative unit; DIVU/REMU only when the divider is built
    function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_MC_DIV_EN
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
        return (op == ALU_MUL);
`endif
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: shared iterative shift-add multiplier and restoring divider.
// One step per cycle for WIDTH cycles; o_res_c is the value produced by the
// step in progress, so it is final on the cycle o_done_c is high.
// Divider datapath is built only when ALU_MC_DIV_EN is defined.
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done_c,
    output logic [WIDTH-1:0] o_res_c
);

    localparam int unsigned CW = $clog2(WIDTH);

    // r_mq: multiplier (shifts right) or dividend/quotient (shifts left)
    // r_mcand: multiplicand (shifts left) or divisor
    // r_acc: partial product or partial remainder
    logic             r_busy;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mq;
    logic [WIDTH-1:0] w_mul_acc;
    logic             w_load;

    assign w_mul_acc = r_acc + (r_mq[0] ? r_mcand : '0);

`ifdef ALU_MC_DIV_EN
    logic             r_div;
    logic             r_rem_sel;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    // Restoring step: shift in next dividend bit, subtract divisor if it fits
    assign w_rem_sh  = {r_acc, r_mq[WIDTH-1]};
    assign w_diff    = w_rem_sh - {1'b0, r_mcand};
    assign w_ge      = ~w_diff[WIDTH];
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_mq[WIDTH-2:0], w_ge};
    assign w_load    = i_start;
    assign o_res_c   = r_div ? (r_rem_sel ? w_rem_nxt : w_quo_nxt) : w_mul_acc;
`else
    assign w_load    = i_start && (i_op == ALU_MUL);
    assign o_res_c   = w_mul_acc;
`endif

    assign o_done_c = r_busy && (r_cnt == '0);

    // Operand load on start, then one iteration step per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mq    <= '0;
`ifdef ALU_MC_DIV_EN
            r_div     <= 1'b0;
            r_rem_sel <= 1'b0;
`endif
        end else if (w_load) begin
            r_busy  <= 1'b1;
            r_cnt   <= CW'(WIDTH - 1);
            r_acc   <= '0;
            r_mcand <= i_b;
            r_mq    <= i_a;
`ifdef ALU_MC_DIV_EN
            r_div     <= (i_op == ALU_DIVU) || (i_op == ALU_REMU);
            r_rem_sel <= (i_op == ALU_REMU);
`endif
        end else if (r_busy) begin
`ifdef ALU_MC_DIV_EN
            if (r_div) begin
                r_acc <= w_rem_nxt;
                r_mq  <= w_quo_nxt;
            end else begin
                r_acc   <= w_mul_acc;
                r_mcand <= r_mcand << 1;
                r_mq    <= r_mq >> 1;
            end
`else
            r_acc   <= w_mul_acc;
            r_mcand <= r_mcand << 1;
            r_mq    <= r_mq >> 1;
`endif
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == '0) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish at the accepting edge; MUL (and DIVU/REMU when
// ALU_MC_DIV_EN is defined) run WIDTH cycles in alu_mc_iter.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [3:0]       alu_ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_sc_res;
    logic             w_sc_ovf;
    logic             w_accept;
    logic             w_multi;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_res;

    assign w_sum    = src_a + src_b;
    assign w_diff   = src_a - src_b;
    assign w_shamt  = src_a[SHW-1:0];
    assign w_accept = in_valid && (r_state == IDLE);
    assign w_multi  = is_multicycle(alu_ctrl);

    // Single-cycle datapath and signed overflow for ADD/SUB
    always_comb begin
        w_sc_res = '0;
        w_sc_ovf = 1'b0;
        case (alu_ctrl)
            ALU_ADD: begin
                w_sc_res = w_sum;
                w_sc_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_SUB: begin
                w_sc_res = w_diff;
                w_sc_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_OR:   w_sc_res = src_a | src_b;
            ALU_SLL:  w_sc_res = src_b << w_shamt;
            ALU_AND:  w_sc_res = src_a & src_b;
            ALU_XOR:  w_sc_res = src_a ^ src_b;
            ALU_SRL:  w_sc_res = src_b >> w_shamt;
            ALU_SRA:  w_sc_res = WIDTH'($signed(src_b) >>> w_shamt);
            ALU_SLT:  w_sc_res = WIDTH'($signed(src_a) < $signed(src_b));
            ALU_SLTU: w_sc_res = WIDTH'(src_a < src_b);
            default:  w_sc_res = '0;
        endcase
    end

    alu_mc_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept && w_multi),
        .i_op     (alu_ctrl),
        .i_a      (src_a),
        .i_b      (src_b),
        .o_done_c (w_iter_done),
        .o_res_c  (w_iter_res)
    );

    // Control FSM with registered handshake outputs and result/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_ready <= 1'b0;
                        if (w_multi) begin
                            r_state <= BUSY;
                        end else begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_sc_res;
                            r_zero      <= (w_sc_res == '0);
                            r_ovf       <= w_sc_ovf;
                        end
                    end
                end
                BUSY: begin
                    if (w_iter_done) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_iter_res;
                        r_zero      <= (w_iter_res == '0);
                        r_ovf       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc (WIDTH=32).
// Divider vectors selected by ALU_MC_DIV_EN.
module tb_alu_mc;
    import alu_mc_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic [3:0]   alu_ctrl;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src_a     (src_a),
        .src_b     (src_b),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .overflow  (overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present an op for exactly one accepting edge; operands stay held
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        alu_ctrl = op;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    // Count cycles after acceptance until out_valid, with a bound
    task automatic wait_done(output int cyc, output logic rdy_seen);
        cyc      = 0;
        rdy_seen = 1'b0;
        while (!out_valid && cyc < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            tick();
            cyc++;
        end
    endtask

    // Single-cycle op: result visible right after the accepting edge
    task automatic sc(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] er, input logic ez, input logic eo);
        issue(op, a, b);
        chk({tag, "_valid"}, W'(out_valid), W'(1));
        chk({tag, "_res"},   result, er);
        chk({tag, "_zero"},  W'(zero), W'(ez));
        chk({tag, "_ovf"},   W'(overflow), W'(eo));
        consume();
        chk({tag, "_idle"},  W'(in_ready), W'(1));
    endtask

    // Multi-cycle op: check latency and result
    task automatic mc(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] er);
        int   cyc;
        logic rdy;
        issue(op, a, b);
        wait_done(cyc, rdy);
        chk({tag, "_lat"},   W'(cyc), W'(32));
        chk({tag, "_nordy"}, W'(rdy), W'(0));
        chk({tag, "_res"},   result, er);
        chk({tag, "_zero"},  W'(zero), W'(er == '0));
        chk({tag, "_ovf"},   W'(overflow), W'(0));
        consume();
    endtask

    initial begin
        int           cyc;
        logic         rdy;
        logic         unstable;
        logic [W-1:0] held;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        src_a     = '0;
        src_b     = '0;
        alu_ctrl  = ALU_ADD;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_in_ready",  W'(in_ready), W'(1));
        chk("rst_out_valid", W'(out_valid), W'(0));
        chk("rst_result",    result, 32'h0);
        chk("rst_zero",      W'(zero), W'(1));
        chk("rst_ovf",       W'(overflow), W'(0));

        // Arithmetic and overflow
        sc("add_ovf", ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        sc("sub_zero", ALU_SUB, 32'd5, 32'd5, 32'h0, 1'b1, 1'b0);
        sc("sub_ovf", ALU_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);
        sc("add_neg", ALU_ADD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Logic ops, shifts, compares, undefined op
        sc("or",   ALU_OR,   32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1'b0);
        sc("and",  ALU_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0);
        sc("xor",  ALU_XOR,  32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'h0, 1'b1, 1'b0);
        sc("sll",  ALU_SLL,  32'h0000_0024, 32'hF000_0001, 32'h0000_0010, 1'b0, 1'b0);
        sc("srl",  ALU_SRL,  32'h0000_0024, 32'hF000_0001, 32'h0F00_0000, 1'b0, 1'b0);
        sc("sra",  ALU_SRA,  32'h0000_0024, 32'hF000_0001, 32'hFF00_0000, 1'b0, 1'b0);
        sc("slt",  ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h1, 1'b0, 1'b0);
        sc("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0, 1'b1, 1'b0);
        sc("undef", 4'b1101, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b1, 1'b0);

        // Reset three cycles into a MUL discards it (result was nonzero before)
        sc("pre_rst", ALU_ADD, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1'b0, 1'b0);
        issue(ALU_MUL, 32'h0001_0000, 32'h0001_0003);
        tick();
        tick();
        chk("midmul_busy", W'(in_ready), W'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_in_ready",  W'(in_ready), W'(1));
        chk("midrst_out_valid", W'(out_valid), W'(0));
        chk("midrst_result",    result, 32'h0);
        chk("midrst_zero",      W'(zero), W'(1));

        // Multiply
        mc("mul", ALU_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
        mc("mul_ones", ALU_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        mc("mul_zero", ALU_MUL, 32'h0000_0000, 32'h1234_5678, 32'h0);

        // Backpressure: outputs frozen, new in_valid ignored while DONE
        issue(ALU_MUL, 32'd12345, 32'd1000);
        wait_done(cyc, rdy);
        chk("bp_lat", W'(cyc), W'(32));
        chk("bp_res", result, 32'd12345000);
        held     = result;
        unstable = 1'b0;
        alu_ctrl = ALU_ADD;
        src_a    = 32'h1;
        src_b    = 32'h1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (result !== held || !out_valid || in_ready || overflow || zero) unstable = 1'b1;
        end
        in_valid = 1'b0;
        chk("bp_stable", W'(unstable), W'(0));
        consume();
        chk("bp_in_ready",  W'(in_ready), W'(1));
        chk("bp_out_valid", W'(out_valid), W'(0));

`ifdef ALU_MC_DIV_EN
        mc("divu",     ALU_DIVU, 32'd100, 32'd7, 32'd14);
        mc("remu",     ALU_REMU, 32'd100, 32'd7, 32'd2);
        mc("divu_by0", ALU_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        mc("remu_by0", ALU_REMU, 32'd9, 32'd0, 32'd9);
        mc("divu_big", ALU_DIVU, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF);
`else
        sc("divu_off", ALU_DIVU, 32'd100, 32'd7, 32'h0, 1'b1, 1'b0);
        sc("remu_off", ALU_REMU, 32'd100, 32'd7, 32'h0, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
